// File: rtl/ahb_rr_arbiter.sv
// Round-robin arbiter sharing one AHB-to-APB bridge among up to four AHB masters.
// Supports HLOCK tenures and hold-count pre-emption, with registered address-phase and data-phase master indices.
module ahb_rr_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int MAX_HOLD       = 16,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   Hclk,
  input  logic                   Hreset,
  input  logic [NUM_MASTERS-1:0] Hbusreq,
  input  logic [NUM_MASTERS-1:0] Hlock,
  input  logic                   Hready,
  input  logic [1:0]             Htrans,
  output logic [NUM_MASTERS-1:0] Hgrant,
  output logic [1:0]             Hmaster,
  output logic [1:0]             Hmaster_data,
  output logic                   Hmastlock
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  localparam logic [1:0] DEF_IDX    = 2'(DEFAULT_MASTER);
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  state_t                 state_q, state_d;
  logic [1:0]             master_q, master_d;
  logic [1:0]             mdata_q, mdata_d;
  logic [NUM_MASTERS-1:0] grant_q;
  logic                   mastlock_q, mastlock_d;
  logic [7:0]             hold_q, hold_d;
  logic [1:0]             rr_q, rr_d;

  logic [3:0]             req4_s;
  logic [3:0]             lock4_s;
  logic [2:0]             pick_all_s;
  logic [2:0]             pick_oth_s;
  state_t                 rel_state_s;
  logic [1:0]             rel_owner_s;
  logic                   unused_s;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] vec;
    vec      = 4'b0000;
    vec[idx] = 1'b1;
    return vec;
  endfunction

  // Returns {found, index}; scans ptr+1 .. ptr so the pointer's own master comes last.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] sel;
    int         idx;
    res = 3'b000;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      idx = (int'(ptr) + i) % NUM_MASTERS;
      sel = idx[1:0];
      if (req[sel]) begin
        res = {1'b1, sel};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign req4_s     = 4'(Hbusreq);
  assign lock4_s    = 4'(Hlock);
  assign pick_all_s = rr_pick(req4_s, rr_q);
  assign pick_oth_s = rr_pick(req4_s & ~onehot4(master_q), rr_q);
  assign unused_s   = Htrans[0];

  // Unlocked release/keep/pre-empt decision, shared by ST_OWN and a lock release.
  always_comb begin
    rel_state_s = ST_OWN;
    rel_owner_s = master_q;
    if (!req4_s[master_q]) begin
      if (pick_oth_s[2]) begin
        rel_state_s = ST_OWN;
        rel_owner_s = pick_oth_s[1:0];
      end else begin
        rel_state_s = ST_IDLE;
        rel_owner_s = DEF_IDX;
      end
    end else if ((hold_q >= HOLD_LIMIT) && pick_oth_s[2]) begin
      rel_state_s = ST_OWN;
      rel_owner_s = pick_oth_s[1:0];
    end else begin
      rel_state_s = ST_OWN;
      rel_owner_s = master_q;
    end
  end

  // Next-state; every register holds its value on Hready=0 edges.
  always_comb begin
    state_d    = state_q;
    master_d   = master_q;
    mdata_d    = mdata_q;
    mastlock_d = mastlock_q;
    hold_d     = hold_q;
    rr_d       = rr_q;
    if (Hready) begin
      mdata_d = master_q;
      case (state_q)
        ST_IDLE: begin
          if (pick_all_s[2]) begin
            state_d  = ST_OWN;
            master_d = pick_all_s[1:0];
          end else begin
            state_d  = ST_IDLE;
            master_d = DEF_IDX;
          end
        end
        ST_OWN: begin
          if (lock4_s[master_q] && req4_s[master_q]) begin
            state_d    = ST_LOCK;
            mastlock_d = 1'b1;
          end else begin
            state_d  = rel_state_s;
            master_d = rel_owner_s;
          end
        end
        ST_LOCK: begin
          if (lock4_s[master_q]) begin
            state_d = ST_LOCK;
          end else begin
            mastlock_d = 1'b0;
            state_d    = rel_state_s;
            master_d   = rel_owner_s;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          master_d   = DEF_IDX;
          mastlock_d = 1'b0;
        end
      endcase

      // Tenure counter restarts with every new owner and on parking.
      if (master_d != master_q) begin
        rr_d   = master_d;
        hold_d = 8'd0;
      end else if (state_d == ST_IDLE) begin
        hold_d = 8'd0;
      end else if ((state_q == ST_OWN) && Htrans[1] && (hold_q != 8'hFF)) begin
        hold_d = hold_q + 8'd1;
      end else begin
        hold_d = hold_q;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q    <= ST_IDLE;
      master_q   <= DEF_IDX;
      mdata_q    <= DEF_IDX;
      grant_q    <= NUM_MASTERS'(onehot4(DEF_IDX));
      mastlock_q <= 1'b0;
      hold_q     <= 8'd0;
      rr_q       <= DEF_IDX;
    end else begin
      state_q    <= state_d;
      master_q   <= master_d;
      mdata_q    <= mdata_d;
      grant_q    <= NUM_MASTERS'(onehot4(master_d));
      mastlock_q <= mastlock_d;
      hold_q     <= hold_d;
      rr_q       <= rr_d;
    end
  end

  assign Hgrant       = grant_q;
  assign Hmaster      = master_q;
  assign Hmaster_data = mdata_q;
  assign Hmastlock    = mastlock_q;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Directed self-checking bench for ahb_rr_arbiter with hand-computed grant sequences.
module tb_ahb_rr_arbiter;

  logic       Hclk;
  logic       Hreset;
  logic [3:0] Hbusreq;
  logic [3:0] Hlock;
  logic       Hready;
  logic [1:0] Htrans;
  logic [3:0] Hgrant;
  logic [1:0] Hmaster;
  logic [1:0] Hmaster_data;
  logic       Hmastlock;

  int n_tests;
  int n_fail;

  ahb_rr_arbiter #(
    .NUM_MASTERS   (4),
    .MAX_HOLD      (16),
    .DEFAULT_MASTER(0)
  ) dut (
    .Hclk        (Hclk),
    .Hreset      (Hreset),
    .Hbusreq     (Hbusreq),
    .Hlock       (Hlock),
    .Hready      (Hready),
    .Htrans      (Htrans),
    .Hgrant      (Hgrant),
    .Hmaster     (Hmaster),
    .Hmaster_data(Hmaster_data),
    .Hmastlock   (Hmastlock)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    Hreset  = 1'b1;
    Hbusreq = 4'b0000;
    Hlock   = 4'b0000;
    Hready  = 1'b1;
    Htrans  = 2'b00;
    tick();
    tick();
    Hreset = 1'b0;

    // Reset values and parking
    check("rst_grant", 32'(Hgrant), 32'h1);
    check("rst_master", 32'(Hmaster), 32'h0);
    check("rst_mdata", 32'(Hmaster_data), 32'h0);
    check("rst_mastlock", 32'(Hmastlock), 32'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("park_grant", 32'(Hgrant), 32'h1);
    end
    check("park_master", 32'(Hmaster), 32'h0);

    // Round-robin sequence M1 -> M3 -> M1
    Hbusreq = 4'b1010;
    tick();
    check("rr_g1", 32'(Hgrant), 32'h2);
    check("rr_m1", 32'(Hmaster), 32'h1);
    check("rr_d1", 32'(Hmaster_data), 32'h0);
    Hbusreq = 4'b1000;
    tick();
    check("rr_g3", 32'(Hgrant), 32'h8);
    check("rr_m3", 32'(Hmaster), 32'h3);
    check("rr_d3", 32'(Hmaster_data), 32'h1);
    Hbusreq = 4'b0010;
    tick();
    check("rr_g1b", 32'(Hgrant), 32'h2);
    check("rr_d3b", 32'(Hmaster_data), 32'h3);

    // Pre-emption after MAX_HOLD beats: M2 -> M0 -> M2
    Hbusreq = 4'b0100;
    tick();
    check("hold_own_m2", 32'(Hgrant), 32'h4);
    Hbusreq = 4'b0101;
    Htrans  = 2'b10;
    for (int i = 0; i < 16; i++) begin
      tick();
      Htrans = (i == 0) ? 2'b10 : 2'b11;
      check("hold_keep_m2", 32'(Hgrant), 32'h4);
    end
    tick();
    check("hold_preempt_g", 32'(Hgrant), 32'h1);
    check("hold_preempt_m", 32'(Hmaster), 32'h0);
    for (int i = 0; i < 16; i++) begin
      tick();
      check("hold_keep_m0", 32'(Hgrant), 32'h1);
    end
    tick();
    check("hold_back_m2", 32'(Hgrant), 32'h4);

    // Locked tenure of M1 with every master requesting
    Hbusreq = 4'b0010;
    tick();
    check("lock_own_m1", 32'(Hgrant), 32'h2);
    for (int i = 0; i < 16; i++) begin
      tick();
      check("lock_solo_m1", 32'(Hgrant), 32'h2);
    end
    Hbusreq = 4'b1111;
    Hlock   = 4'b0010;
    tick();
    check("lock_enter_g", 32'(Hgrant), 32'h2);
    check("lock_enter_ml", 32'(Hmastlock), 32'h1);
    for (int i = 0; i < 40; i++) begin
      tick();
      check("lock_hold_g", 32'(Hgrant), 32'h2);
      check("lock_hold_ml", 32'(Hmastlock), 32'h1);
    end
    Hlock = 4'b0000;
    tick();
    check("unlock_g", 32'(Hgrant), 32'h4);
    check("unlock_ml", 32'(Hmastlock), 32'h0);

    // Hready=0 freeze, then M3 wins on the first ready edge
    Hbusreq = 4'b0001;
    Htrans  = 2'b00;
    tick();
    check("frz_own_m0", 32'(Hgrant), 32'h1);
    check("frz_own_d", 32'(Hmaster_data), 32'h2);
    Hready  = 1'b0;
    Hbusreq = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("frz_g", 32'(Hgrant), 32'h1);
      check("frz_m", 32'(Hmaster), 32'h0);
      check("frz_d", 32'(Hmaster_data), 32'h2);
    end
    Hready = 1'b1;
    tick();
    check("frz_rel_g", 32'(Hgrant), 32'h8);
    check("frz_rel_m", 32'(Hmaster), 32'h3);
    check("frz_rel_d0", 32'(Hmaster_data), 32'h0);
    tick();
    check("frz_rel_d3", 32'(Hmaster_data), 32'h3);

    // Reset mid-lock of M2, then arbitration restarts from the default pointer
    Hbusreq = 4'b0100;
    Hlock   = 4'b0100;
    tick();
    check("rl_own_m2", 32'(Hgrant), 32'h4);
    tick();
    check("rl_locked", 32'(Hmastlock), 32'h1);
    Hreset = 1'b1;
    tick();
    Hreset  = 1'b0;
    Hbusreq = 4'b1100;
    Hlock   = 4'b0000;
    check("rl_rst_g", 32'(Hgrant), 32'h1);
    check("rl_rst_m", 32'(Hmaster), 32'h0);
    check("rl_rst_d", 32'(Hmaster_data), 32'h0);
    check("rl_rst_ml", 32'(Hmastlock), 32'h0);
    tick();
    check("rl_restart_g", 32'(Hgrant), 32'h4);
    check("rl_restart_m", 32'(Hmaster), 32'h2);

    // Owner drops with nobody else requesting -> park on the default master
    Hbusreq = 4'b0000;
    tick();
    check("park_again_g", 32'(Hgrant), 32'h1);
    check("park_again_m", 32'(Hmaster), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
